// File: rtl/npu_seq_pkg.sv
// npu_seq_pkg: register map, CTRL/STATUS bit positions and FSM encoding for npu_job_sequencer.
package npu_seq_pkg;
    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_TILE_CNT = 8'h08;
    localparam logic [7:0] OFF_TILE_IDX = 8'h0C;
    localparam logic [7:0] OFF_TMO_LIM  = 8'h10;
    localparam logic [7:0] OFF_PERF_CYC = 8'h14;
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_TMO     = 3;
    localparam int ST_ABORTED = 4;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} seq_state_e;
endpackage

// File: rtl/npu_seq_wb_regs.sv
// npu_seq_wb_regs: Wishbone decode, single-cycle ack and register file of the job sequencer.
module npu_seq_wb_regs
    import npu_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          TILE_W    = 16,
    parameter int          TMO_W     = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              busy_i,
    input  logic [TILE_W-1:0] tile_idx_i,
    input  logic [31:0]       perf_i,
    input  logic              set_done_i,
    input  logic              set_err_i,
    input  logic              set_tmo_i,
    input  logic              set_abort_i,
    output logic              start_o,
    output logic              abort_o,
    output logic [TILE_W-1:0] tile_cnt_o,
    output logic [TMO_W-1:0]  tmo_lim_o,
    output logic [2:0]        irq_o
);
    logic [7:0] off;
    logic hit, wr, wr_ctrl, w1c;
    logic ack_q, start_q, abort_q, irq_en_q, done_q, err_q, tmo_q, aborted_q;
    logic [31:0] dat_q, rd_data;
    logic [4:0] status;
    logic [TILE_W-1:0] tile_cnt_q;
    logic [TMO_W-1:0] tmo_lim_q;
    logic unused_ok;

    assign off     = wbs_adr_i[7:0];
    // ack_q blocks a new hit, so back-to-back requests are served every other cycle
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~ack_q;
    assign wr      = hit & wbs_we_i;
    assign wr_ctrl = wr & wbs_sel_i[0] & (off == OFF_CTRL);
    assign w1c     = wr & wbs_sel_i[0] & (off == OFF_STATUS);
    assign status  = {aborted_q, tmo_q, err_q, done_q, busy_i};

    assign rd_data = (off == OFF_CTRL)     ? {29'd0, irq_en_q, 2'd0}
                   : (off == OFF_STATUS)   ? {27'd0, status}
                   : (off == OFF_TILE_CNT) ? 32'(tile_cnt_q)
                   : (off == OFF_TILE_IDX) ? 32'(tile_idx_i)
                   : (off == OFF_TMO_LIM)  ? 32'(tmo_lim_q)
                   : (off == OFF_PERF_CYC) ? perf_i
                   : 32'd0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            aborted_q  <= 1'b0;
            tile_cnt_q <= '0;
            tmo_lim_q  <= '0;
        end else begin
            ack_q     <= hit;
            dat_q     <= (hit & ~wbs_we_i) ? rd_data : '0;
            start_q   <= wr_ctrl & wbs_dat_i[CTRL_START];
            abort_q   <= wr_ctrl & wbs_dat_i[CTRL_ABORT];
            irq_en_q  <= wr_ctrl ? wbs_dat_i[CTRL_IRQ_EN] : irq_en_q;
            done_q    <= set_done_i  | (done_q    & ~(w1c & wbs_dat_i[ST_DONE]));
            err_q     <= set_err_i   | (err_q     & ~(w1c & wbs_dat_i[ST_ERR]));
            tmo_q     <= set_tmo_i   | (tmo_q     & ~(w1c & wbs_dat_i[ST_TMO]));
            aborted_q <= set_abort_i | (aborted_q & ~(w1c & wbs_dat_i[ST_ABORTED]));
            for (int b = 0; b < TILE_W; b++)
                if (wr & ~busy_i & (off == OFF_TILE_CNT) & wbs_sel_i[b/8])
                    tile_cnt_q[b] <= wbs_dat_i[b];
            for (int b = 0; b < TMO_W; b++)
                if (wr & (off == OFF_TMO_LIM) & wbs_sel_i[b/8])
                    tmo_lim_q[b] <= wbs_dat_i[b];
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign start_o    = start_q;
    assign abort_o    = abort_q;
    assign tile_cnt_o = tile_cnt_q;
    assign tmo_lim_o  = tmo_lim_q;
    assign irq_o      = {1'b0, irq_en_q & (err_q | tmo_q | aborted_q), irq_en_q & done_q};
    assign unused_ok  = &{1'b0, wbs_sel_i, wbs_dat_i};
endmodule

// File: rtl/npu_job_sequencer.sv
// npu_job_sequencer: Wishbone-programmed multi-tile job FSM driving the NPU start/done handshake.
// Define NPU_PERF_CNT_EN to add the PERF_CYC busy-cycle counter at offset 0x14.
module npu_job_sequencer
    import npu_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          TILE_W    = 16,
    parameter int          TMO_W     = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              npu_start_o,
    output logic [TILE_W-1:0] npu_tile_o,
    input  logic              npu_done_i,
    input  logic              npu_err_i,
    output logic [2:0]        irq_o
);
    seq_state_e state_q, state_d;
    logic start_req, abort_req, start_q, busy_q, last;
    logic ev_done, ev_err, ev_tmo, ev_abort;
    logic [TILE_W-1:0] tile_cnt, idx_q;
    logic [TMO_W-1:0] tmo_lim, tmo_q, tmo_d;
    logic [31:0] perf;

    npu_seq_wb_regs #(.ADDR_BASE(ADDR_BASE), .TILE_W(TILE_W), .TMO_W(TMO_W)) u_regs (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .busy_i     (busy_q),
        .tile_idx_i (idx_q),
        .perf_i     (perf),
        .set_done_i (ev_done),
        .set_err_i  (ev_err),
        .set_tmo_i  (ev_tmo),
        .set_abort_i(ev_abort),
        .start_o    (start_req),
        .abort_o    (abort_req),
        .tile_cnt_o (tile_cnt),
        .tmo_lim_o  (tmo_lim),
        .irq_o      (irq_o)
    );

    // abort outranks every NPU input; err > done > timeout inside WAIT
    always_comb begin
        state_d  = state_q;
        ev_done  = 1'b0;
        ev_err   = 1'b0;
        ev_tmo   = 1'b0;
        ev_abort = 1'b0;
        tmo_d    = tmo_q + 1'b1;
        last     = idx_q == tile_cnt - 1'b1;
        if (state_q != S_IDLE && abort_req) begin
            state_d  = S_FINISH;
            ev_abort = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ev_done = start_req && tile_cnt == '0;
                    state_d = (start_req && tile_cnt != '0) ? S_ISSUE : S_IDLE;
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (npu_err_i) begin
                        ev_err  = 1'b1;
                        state_d = S_FINISH;
                    end else if (npu_done_i) begin
                        ev_done = last;
                        state_d = last ? S_FINISH : S_ISSUE;
                    end else if (tmo_lim != '0 && tmo_d == tmo_lim) begin
                        ev_tmo  = 1'b1;
                        state_d = S_FINISH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= state_d == S_ISSUE;
            busy_q  <= state_d inside {S_ISSUE, S_WAIT};
            tmo_q   <= (state_q == S_WAIT) ? tmo_d : '0;
            if (state_d == S_ISSUE)
                idx_q <= (state_q == S_IDLE) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef NPU_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (state_q == S_IDLE && start_req))
            perf_q <= '0;
        else if (state_q inside {S_ISSUE, S_WAIT} && perf_q != '1)
            perf_q <= perf_q + 1'b1;
    end
    assign perf = perf_q;
`else
    assign perf = '0;
`endif

    assign npu_start_o = start_q;
    assign npu_tile_o  = idx_q;
endmodule

// File: tb/tb_npu_job_sequencer.sv
// tb_npu_job_sequencer: table-driven register checks plus directed multi-tile job sequences.
module tb_npu_job_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NV = 18;

    typedef struct packed {
        logic        we;
        logic [7:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic clk, rst, cyc, stb, we, ack, npu_start, npu_done, npu_err;
    logic [3:0] sel;
    logic [31:0] adr, dat_w, dat_r, rd;
    logic [15:0] npu_tile;
    logic [2:0] irq;
    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int s0, lat, acks;
    vec_t vecs [NV];

    npu_job_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .npu_start_o(npu_start),
        .npu_tile_o (npu_tile),
        .npu_done_i (npu_done),
        .npu_err_i  (npu_err),
        .irq_o      (irq)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) if (npu_start) start_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
        int n = 0;
        cyc = 1; stb = 1; we = w; adr = BASE | {24'd0, off}; dat_w = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        chk("wb_ack", {31'd0, ack}, 32'd1);
        r = dat_r;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, off, d, 4'hF, r);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, off, 32'd0, 4'hF, r);
        chk(name, r, exp);
    endtask

    task automatic wait_start(input int t);
        int n = 0;
        while (!npu_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("start_seen_t%0d", t), {31'd0, npu_start}, 32'd1);
        chk($sformatf("tile_t%0d", t), {16'd0, npu_tile}, t);
    endtask

    task automatic done_pulse();
        npu_done = 1;
        @(negedge clk);
        npu_done = 0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         4'hF, 32'h0};
        vecs[2]  = '{1'b1, 8'h08, 32'hABCD_1234, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0000_1234};
        vecs[4]  = '{1'b1, 8'h08, 32'h0000_5600, 4'h2, 32'h0};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0000_5634};
        vecs[6]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'h1, 32'h0};
        vecs[7]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h0000_00FF};
        vecs[8]  = '{1'b1, 8'h00, 32'h0000_0004, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h0};
        vecs[10] = '{1'b1, 8'h00, 32'h0000_0004, 4'h1, 32'h0};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h0000_0004};
        vecs[12] = '{1'b0, 8'h0C, 32'h0,         4'hF, 32'h0};
        vecs[13] = '{1'b0, 8'h14, 32'h0,         4'hF, 32'h0};
        vecs[14] = '{1'b0, 8'h20, 32'h0,         4'hF, 32'h0};
        vecs[15] = '{1'b1, 8'h00, 32'h0,         4'h1, 32'h0};
        vecs[16] = '{1'b1, 8'h10, 32'h0,         4'h3, 32'h0};
        vecs[17] = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h0};
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        npu_done = 0; npu_err = 0; rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_start", {31'd0, npu_start}, 32'd0);
        chk("rst_tile", {16'd0, npu_tile}, 32'd0);
        chk("rst_irq", {29'd0, irq}, 32'd0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            wb(vecs[i].we, vecs[i].off, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // three tiles, NPU answers done five cycles after each start
        wr(8'h08, 3);
        wr(8'h10, 0);
        s0 = start_cnt;
        wr(8'h00, 5);
        for (int t = 0; t < 3; t++) begin
            wait_start(t);
            repeat (4) @(negedge clk);
            done_pulse();
        end
        repeat (5) @(negedge clk);
        chk("j1_starts", start_cnt - s0, 3);
        chk("j1_tile_held", {16'd0, npu_tile}, 2);
        chk("j1_irq", {29'd0, irq}, 32'h1);
        rd_chk("j1_status", 8'h04, 32'h2);
        rd_chk("j1_tile_idx", 8'h0C, 32'h2);
        wr(8'h04, 32'h1E);
        chk("j1_irq_clr", {29'd0, irq}, 32'h0);

        // zero tiles: DONE right after the ack, no pulse
        wr(8'h08, 0);
        s0 = start_cnt;
        wr(8'h00, 5);
        chk("z_irq_ack_cycle", {31'd0, irq[0]}, 32'd0);
        @(negedge clk);
        chk("z_irq_next_cycle", {31'd0, irq[0]}, 32'd1);
        repeat (5) @(negedge clk);
        chk("z_starts", start_cnt - s0, 0);
        rd_chk("z_status", 8'h04, 32'h2);
        wr(8'h04, 32'h2);
        chk("z_irq_clr", {29'd0, irq}, 32'h0);

        // timeout with a silent NPU
        wr(8'h08, 4);
        wr(8'h10, 10);
        s0 = start_cnt;
        wr(8'h00, 5);
        wait_start(0);
        lat = 0;
        for (int k = 1; k <= 14 && lat == 0; k++) begin
            @(negedge clk);
            if (irq[1]) lat = k;
        end
        chk("tmo_latency_10_or_11", {31'd0, lat == 10 || lat == 11}, 32'd1);
        repeat (5) @(negedge clk);
        chk("tmo_starts", start_cnt - s0, 1);
        rd_chk("tmo_status", 8'h04, 32'h8);
        chk("tmo_irq", {29'd0, irq}, 32'h2);
        wr(8'h04, 32'h8);
        rd_chk("tmo_status_clr", 8'h04, 32'h0);
        chk("tmo_irq_clr", {29'd0, irq}, 32'h0);

        // err and done together on tile 0
        wr(8'h08, 2);
        wr(8'h10, 0);
        s0 = start_cnt;
        wr(8'h00, 5);
        wait_start(0);
        repeat (2) @(negedge clk);
        npu_err = 1; npu_done = 1;
        @(negedge clk);
        npu_err = 0; npu_done = 0;
        repeat (10) @(negedge clk);
        chk("err_starts", start_cnt - s0, 1);
        rd_chk("err_status", 8'h04, 32'h4);
        chk("err_irq", {29'd0, irq}, 32'h2);
        wr(8'h04, 32'h4);

        // abort during WAIT on tile 1, TILE_CNT write while busy ignored
        wr(8'h08, 3);
        s0 = start_cnt;
        wr(8'h00, 5);
        wait_start(0);
        repeat (2) @(negedge clk);
        done_pulse();
        wait_start(1);
        wr(8'h08, 7);
        wr(8'h00, 6);
        chk("ab_irq_ack_cycle", {31'd0, irq[1]}, 32'd0);
        @(negedge clk);
        chk("ab_irq_next_cycle", {31'd0, irq[1]}, 32'd1);
        rd_chk("ab_status", 8'h04, 32'h10);
        rd_chk("ab_tile_cnt", 8'h08, 32'h3);
        done_pulse();
        repeat (5) @(negedge clk);
        chk("ab_starts", start_cnt - s0, 2);
        rd_chk("ab_status_idle", 8'h04, 32'h10);

        // reset mid-job with ABORTED still pending
        wr(8'h00, 5);
        wait_start(0);
        repeat (2) @(negedge clk);
        done_pulse();
        wait_start(1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mr_ack", {31'd0, ack}, 32'd0);
        chk("mr_dat", dat_r, 32'd0);
        chk("mr_start", {31'd0, npu_start}, 32'd0);
        chk("mr_tile", {16'd0, npu_tile}, 32'd0);
        chk("mr_irq", {29'd0, irq}, 32'd0);
        rst = 0;
        @(negedge clk);
        rd_chk("mr_status", 8'h04, 32'h0);
        rd_chk("mr_ctrl", 8'h00, 32'h0);
        rd_chk("mr_tile_cnt", 8'h08, 32'h0);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0100;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 0; stb = 0;
        chk("miss_acks", acks, 0);
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        chk("mr_no_starts", start_cnt - s0, 0);
        chk("mr_irq_quiet", {29'd0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
